// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: state encoding, kernel size and address widths shared by the
// convolution sequencer and its window address generator.
package conv_seq_pkg;

  typedef enum logic [2:0] {IDLE, KLOAD, STREAM, READOUT, DONE} state_t;

  localparam int KSIZE = 9;
  localparam int IN_AW = 14;
  localparam int W_AW  = 9;
  localparam int B_AW  = 4;
  localparam int PS_AW = 12;

  // Counter width helper that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// conv_window_addr_gen: follows the raster position of input reads, flags valid 3x3
// windows and delays them PIPE_LAT cycles into the partial-sum SRAM access triple.
module conv_window_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int IMG_H    = 58,
  parameter int IMG_W    = 58,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue,
  input  logic             first_ch,
  input  logic             sweep,
  input  logic [PS_AW-1:0] sweep_addr,
  output logic             ps_sram_en,
  output logic             ps_sram_rst_en,
  output logic [PS_AW-1:0] ps_sram_addr
);

  localparam int OUT_PIX = (IMG_H - 2) * (IMG_W - 2);
  localparam int RW      = cw(IMG_H);
  localparam int QW      = cw(IMG_W);

  logic [RW-1:0]    row;
  logic [QW-1:0]    col;
  logic [PS_AW-1:0] oaddr;
  logic             win;
  logic             pre_v;
  logic             pre_rst;
  logic [PS_AW-1:0] pre_addr;

  assign win = issue && (row >= RW'(2)) && (col >= QW'(2));

  // The output index advances by one per valid window, so no multiply is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= '0;
      col   <= '0;
      oaddr <= '0;
    end else if (clr) begin
      row   <= '0;
      col   <= '0;
      oaddr <= '0;
    end else if (issue) begin
      if (col == QW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (win) oaddr <= (oaddr == PS_AW'(OUT_PIX - 1)) ? '0 : oaddr + 1'b1;
    end
  end

  // PIPE_LAT-1 stages here; the output register below supplies the last one.
  generate
    if (PIPE_LAT <= 1) begin : g_direct
      assign pre_v    = win;
      assign pre_rst  = win & first_ch;
      assign pre_addr = oaddr;
    end else begin : g_dly
      logic             dv [PIPE_LAT-1];
      logic             dr [PIPE_LAT-1];
      logic [PS_AW-1:0] da [PIPE_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < PIPE_LAT - 1; k++) begin
            dv[k] <= 1'b0;
            dr[k] <= 1'b0;
            da[k] <= '0;
          end
        end else begin
          dv[0] <= win;
          dr[0] <= win & first_ch;
          da[0] <= oaddr;
          for (int k = 1; k < PIPE_LAT - 1; k++) begin
            dv[k] <= dv[k-1];
            dr[k] <= dr[k-1];
            da[k] <= da[k-1];
          end
        end
      end

      assign pre_v    = dv[PIPE_LAT-2];
      assign pre_rst  = dr[PIPE_LAT-2];
      assign pre_addr = da[PIPE_LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_sram_en     <= 1'b0;
      ps_sram_rst_en <= 1'b0;
      ps_sram_addr   <= '0;
    end else begin
      ps_sram_en     <= pre_v | sweep;
      ps_sram_rst_en <= pre_rst & ~sweep;
      if (sweep)      ps_sram_addr <= sweep_addr;
      else if (pre_v) ps_sram_addr <= pre_addr;
    end
  end

endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: control initiator for the 4-PE convolution datapath.
// Defining CONV_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter on perf_cycles.
//   state   | meaning
//   IDLE    | waiting for start
//   KLOAD   | 9-cycle weight load for channel ch
//   STREAM  | raster read of channel ch, then PIPE_LAT drain cycles
//   READOUT | partial-sum sweep with bias, results one cycle behind
//   DONE    | one-cycle completion pulse
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int IMG_H    = 58,
  parameter int IMG_W    = 58,
  parameter int CH_IN    = 3,
  parameter int PIPE_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  group,
  output logic        busy,
  output logic        done,
  output logic        input_sram_en,
  output logic [13:0] input_sram_rd_addr,
  output logic        kernel_rf_en,
  output logic [8:0]  kernel1_rf_rd_addr,
  output logic [8:0]  kernel2_rf_rd_addr,
  output logic [8:0]  kernel3_rf_rd_addr,
  output logic [8:0]  kernel4_rf_rd_addr,
  output logic        bias_rf_en,
  output logic [3:0]  bias_rf_rd_addr,
  output logic        ps_sram_en,
  output logic        ps_sram_rst_en,
  output logic [11:0] ps_sram_addr,
  output logic        result_valid,
  output logic [11:0] result_addr
`ifdef CONV_SEQ_PERF_CNT_EN
 ,output logic [31:0] perf_cycles
`endif
);

  localparam int IMG_PIX    = IMG_H * IMG_W;
  localparam int OUT_PIX    = (IMG_H - 2) * (IMG_W - 2);
  localparam int STREAM_LEN = IMG_PIX + PIPE_LAT;
  localparam int TW         = cw(STREAM_LEN + KSIZE + OUT_PIX);
  localparam int CW         = cw(CH_IN);

  state_t           state;
  logic [TW-1:0]    tmr;
  logic [CW-1:0]    ch;
  logic [IN_AW-1:0] pix_base;
  logic [W_AW-1:0]  w_base;
  logic [W_AW-1:0]  kaddr;
  logic             accept;
  logic             last_ch;
  logic             sweep;
  logic [PS_AW-1:0] sweep_addr;

  assign accept  = (state == IDLE) && start;
  assign last_ch = (ch == CW'(CH_IN - 1));

  assign kernel1_rf_rd_addr = kaddr;
  assign kernel2_rf_rd_addr = kaddr;
  assign kernel3_rf_rd_addr = kaddr;
  assign kernel4_rf_rd_addr = kaddr;

  // Read-out request for the next cycle; the generator registers it.
  always_comb begin
    sweep      = 1'b0;
    sweep_addr = '0;
    if (state == STREAM && tmr == '0 && last_ch) sweep = 1'b1;
    if (state == READOUT && tmr > TW'(1)) begin
      sweep      = 1'b1;
      sweep_addr = ps_sram_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      tmr                <= '0;
      ch                 <= '0;
      pix_base           <= '0;
      w_base             <= '0;
      kaddr              <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      input_sram_en      <= 1'b0;
      input_sram_rd_addr <= '0;
      kernel_rf_en       <= 1'b0;
      bias_rf_en         <= 1'b0;
      bias_rf_rd_addr    <= '0;
      result_valid       <= 1'b0;
      result_addr        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= KLOAD;
            tmr             <= TW'(KSIZE - 1);
            ch              <= '0;
            pix_base        <= '0;
            w_base          <= '0;
            kaddr           <= '0;
            busy            <= 1'b1;
            kernel_rf_en    <= 1'b1;
            bias_rf_rd_addr <= group;
          end
        end
        KLOAD: begin
          if (tmr == '0) begin
            state              <= STREAM;
            tmr                <= TW'(STREAM_LEN - 1);
            kernel_rf_en       <= 1'b0;
            input_sram_en      <= 1'b1;
            input_sram_rd_addr <= pix_base;
          end else begin
            tmr   <= tmr - 1'b1;
            kaddr <= kaddr + 1'b1;
          end
        end
        STREAM: begin
          if (tmr == '0) begin
            input_sram_en <= 1'b0;
            if (!last_ch) begin
              state        <= KLOAD;
              tmr          <= TW'(KSIZE - 1);
              ch           <= ch + 1'b1;
              pix_base     <= pix_base + IN_AW'(IMG_PIX);
              w_base       <= w_base + W_AW'(KSIZE);
              kaddr        <= w_base + W_AW'(KSIZE);
              kernel_rf_en <= 1'b1;
            end else begin
              state      <= READOUT;
              tmr        <= TW'(OUT_PIX);
              bias_rf_en <= 1'b1;
            end
          end else begin
            tmr <= tmr - 1'b1;
            // The final PIPE_LAT cycles only drain the window pipeline.
            if (tmr > TW'(PIPE_LAT)) input_sram_rd_addr <= input_sram_rd_addr + 1'b1;
            else                     input_sram_en      <= 1'b0;
          end
        end
        READOUT: begin
          if (tmr == '0) begin
            state        <= DONE;
            done         <= 1'b1;
            result_valid <= 1'b0;
          end else begin
            tmr          <= tmr - 1'b1;
            result_valid <= 1'b1;
            result_addr  <= (tmr == TW'(OUT_PIX)) ? '0 : result_addr + 1'b1;
            if (tmr == TW'(1)) bias_rf_en <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_window_addr_gen #(
    .IMG_H    (IMG_H),
    .IMG_W    (IMG_W),
    .PIPE_LAT (PIPE_LAT)
  ) u_win (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (accept),
    .issue          (input_sram_en),
    .first_ch       (ch == '0),
    .sweep          (sweep),
    .sweep_addr     (sweep_addr),
    .ps_sram_en     (ps_sram_en),
    .ps_sram_rst_en (ps_sram_rst_en),
    .ps_sram_addr   (ps_sram_addr)
  );

`ifdef CONV_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           perf_cycles <= '0;
    else if (accept)                      perf_cycles <= '0;
    else if (busy && perf_cycles != '1)   perf_cycles <= perf_cycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: directed bench for a 6x6, 2-channel, PIPE_LAT=3 sequencer
// (114 busy cycles per transaction); covers perf_cycles when CONV_SEQ_PERF_CNT_EN is set.
module tb_conv_layer_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  group;
  logic        busy, done, input_sram_en, kernel_rf_en, bias_rf_en;
  logic        ps_sram_en, ps_sram_rst_en, result_valid;
  logic [13:0] input_sram_rd_addr;
  logic [8:0]  kernel1_rf_rd_addr, kernel2_rf_rd_addr, kernel3_rf_rd_addr, kernel4_rf_rd_addr;
  logic [3:0]  bias_rf_rd_addr;
  logic [11:0] ps_sram_addr, result_addr;
`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int checks;
  int errors;

  typedef struct {int k; int a; int r;} ev_t;

  logic        c_busy [256];
  logic        c_done [256];
  logic        c_ise  [256];
  logic [13:0] c_ira  [256];
  logic        c_kre  [256];
  logic [35:0] c_ka   [256];
  logic        c_be   [256];
  logic        c_pe   [256];
  logic        c_pr   [256];
  logic [11:0] c_pa   [256];
  logic        c_rv   [256];
  logic [11:0] c_ra   [256];

  logic [85:0] all_out;
  assign all_out = {busy, done, input_sram_en, input_sram_rd_addr, kernel_rf_en,
                    kernel1_rf_rd_addr, kernel2_rf_rd_addr, kernel3_rf_rd_addr, kernel4_rf_rd_addr,
                    bias_rf_en, bias_rf_rd_addr, ps_sram_en, ps_sram_rst_en, ps_sram_addr,
                    result_valid, result_addr};

  conv_layer_sequencer #(
    .IMG_H (6), .IMG_W (6), .CH_IN (2), .PIPE_LAT (3)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .group              (group),
    .busy               (busy),
    .done               (done),
    .input_sram_en      (input_sram_en),
    .input_sram_rd_addr (input_sram_rd_addr),
    .kernel_rf_en       (kernel_rf_en),
    .kernel1_rf_rd_addr (kernel1_rf_rd_addr),
    .kernel2_rf_rd_addr (kernel2_rf_rd_addr),
    .kernel3_rf_rd_addr (kernel3_rf_rd_addr),
    .kernel4_rf_rd_addr (kernel4_rf_rd_addr),
    .bias_rf_en         (bias_rf_en),
    .bias_rf_rd_addr    (bias_rf_rd_addr),
    .ps_sram_en         (ps_sram_en),
    .ps_sram_rst_en     (ps_sram_rst_en),
    .ps_sram_addr       (ps_sram_addr),
    .result_valid       (result_valid),
    .result_addr        (result_addr)
`ifdef CONV_SEQ_PERF_CNT_EN
   ,.perf_cycles        (perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start pulse at cycle 0, then record cycles 1..n at the falling edge.
  task automatic run_txn(input logic [3:0] g, input int n);
    @(negedge clk);
    start = 1'b1;
    group = g;
    @(negedge clk);
    start = 1'b0;
    group = 4'd0;
    for (int k = 1; k <= n; k++) begin
      c_busy[k] = busy;
      c_done[k] = done;
      c_ise[k]  = input_sram_en;
      c_ira[k]  = input_sram_rd_addr;
      c_kre[k]  = kernel_rf_en;
      c_ka[k]   = {kernel1_rf_rd_addr, kernel2_rf_rd_addr, kernel3_rf_rd_addr, kernel4_rf_rd_addr};
      c_be[k]   = bias_rf_en;
      c_pe[k]   = ps_sram_en;
      c_pr[k]   = ps_sram_rst_en;
      c_pa[k]   = ps_sram_addr;
      c_rv[k]   = result_valid;
      c_ra[k]   = result_addr;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    group = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL idle_outputs: got %h, expected 0", all_out);
    end
  endtask

  task automatic test_kernel_load();
    logic exp_en;
    int   exp_a;
    run_txn(4'd5, 120);
    for (int k = 1; k <= 120; k++) begin
      exp_en = (k >= 1 && k <= 9) || (k >= 49 && k <= 57);
      checks++;
      if (c_kre[k] !== exp_en) begin
        errors++;
        $display("FAIL kernel_rf_en cycle %0d: got %b, expected %b", k, c_kre[k], exp_en);
      end
      if (exp_en) begin
        exp_a = (k <= 9) ? k - 1 : k - 49 + 9;
        checks++;
        if (c_ka[k] !== {4{9'(exp_a)}}) begin
          errors++;
          $display("FAIL kernel_addr cycle %0d: got %h, expected four x %0d", k, c_ka[k], exp_a);
        end
      end
    end
    checks++;
    if (bias_rf_rd_addr !== 4'd5) begin
      errors++;
      $display("FAIL bias_rf_rd_addr: got %0d, expected 5", bias_rf_rd_addr);
    end
  endtask

  task automatic test_stream();
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  e;
    logic exp_en;
    int   exp_a;
    run_txn(4'd2, 120);
    for (int k = 1; k <= 120; k++) begin
      exp_en = (k >= 10 && k <= 45) || (k >= 58 && k <= 93);
      checks++;
      if (c_ise[k] !== exp_en) begin
        errors++;
        $display("FAIL input_sram_en cycle %0d: got %b, expected %b", k, c_ise[k], exp_en);
      end
      if (exp_en) begin
        exp_a = (k <= 45) ? k - 10 : k - 22;
        checks++;
        if (c_ira[k] !== 14'(exp_a)) begin
          errors++;
          $display("FAIL input_sram_rd_addr cycle %0d: got %0d, expected %0d", k, c_ira[k], exp_a);
        end
      end
      if (c_pe[k] === 1'b1) begin
        e.k = k; e.a = int'(c_pa[k]); e.r = int'(c_pr[k]);
        obs_q.push_back(e);
      end
    end
    // Window (r,q) is read at stream offset r*6+q and reaches ps_sram 3 cycles later.
    for (int c = 0; c < 2; c++)
      for (int r = 2; r < 6; r++)
        for (int q = 2; q < 6; q++) begin
          e.k = ((c == 0) ? 10 : 58) + r * 6 + q + 3;
          e.a = (r - 2) * 4 + (q - 2);
          e.r = (c == 0) ? 1 : 0;
          exp_q.push_back(e);
        end
    for (int j = 0; j < 16; j++) begin
      e.k = 97 + j; e.a = j; e.r = 0;
      exp_q.push_back(e);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ps_sram_pulse_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].k != exp_q[i].k || obs_q[i].a != exp_q[i].a || obs_q[i].r != exp_q[i].r) begin
        errors++;
        $display("FAIL ps_sram_pulse %0d: got cycle %0d addr %0d rst %0d, expected cycle %0d addr %0d rst %0d",
                 i, obs_q[i].k, obs_q[i].a, obs_q[i].r, exp_q[i].k, exp_q[i].a, exp_q[i].r);
      end
    end
  endtask

  task automatic test_readout();
    logic exp_be, exp_rv, exp_done, exp_busy;
    run_txn(4'd9, 120);
    for (int k = 1; k <= 120; k++) begin
      exp_be   = (k >= 97 && k <= 112);
      exp_rv   = (k >= 98 && k <= 113);
      exp_done = (k == 114);
      exp_busy = (k <= 114);
      checks++;
      if ({c_be[k], c_rv[k], c_done[k], c_busy[k]} !== {exp_be, exp_rv, exp_done, exp_busy}) begin
        errors++;
        $display("FAIL readout_ctrl cycle %0d: got be/rv/done/busy %b%b%b%b, expected %b%b%b%b",
                 k, c_be[k], c_rv[k], c_done[k], c_busy[k], exp_be, exp_rv, exp_done, exp_busy);
      end
      if (exp_rv) begin
        checks++;
        if (c_ra[k] !== 12'(k - 98)) begin
          errors++;
          $display("FAIL result_addr cycle %0d: got %0d, expected %0d", k, c_ra[k], k - 98);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nbusy, ndone, kdone;
    @(negedge clk);
    start = 1'b1;
    group = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if (input_sram_en !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reads: got input_sram_en %b, expected 1", input_sram_en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, expected 0", all_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h, expected 0", all_out);
    end
    run_txn(4'd3, 120);
    nbusy = 0; ndone = 0; kdone = 0;
    for (int k = 1; k <= 120; k++) begin
      if (c_busy[k] === 1'b1) nbusy++;
      if (c_done[k] === 1'b1) begin ndone++; kdone = k; end
    end
    checks++;
    if (nbusy != 114) begin
      errors++;
      $display("FAIL restart_busy_cycles: got %0d, expected 114", nbusy);
    end
    checks++;
    if (ndone != 1 || kdone != 114) begin
      errors++;
      $display("FAIL restart_done: got %0d pulses last at %0d, expected 1 at 114", ndone, kdone);
    end
  endtask

  task automatic test_start_collision();
    logic exp_busy, exp_done;
    @(negedge clk);
    start = 1'b1;
    group = 4'd1;
    for (int k = 1; k <= 232; k++) begin
      @(negedge clk);
      exp_busy = (k % 115) != 0;
      exp_done = (k % 115) == 114;
      checks++;
      if ({busy, done} !== {exp_busy, exp_done}) begin
        errors++;
        $display("FAIL collision cycle %0d: got busy/done %b%b, expected %b%b", k, busy, done, exp_busy, exp_done);
      end
    end
    start = 1'b0;
    repeat (130) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL collision_drain: got busy %b, expected 0", busy);
    end
  endtask

`ifdef CONV_SEQ_PERF_CNT_EN
  task automatic test_perf();
    run_txn(4'd0, 120);
    checks++;
    if (perf_cycles !== 32'd114) begin
      errors++;
      $display("FAIL perf_after_done: got %0d, expected 114", perf_cycles);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (perf_cycles !== 32'd114) begin
      errors++;
      $display("FAIL perf_hold: got %0d, expected 114", perf_cycles);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_clear: got %0d, expected 0", perf_cycles);
    end
    repeat (120) @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    group  = 4'd0;
    test_reset();
    test_kernel_load();
    test_stream();
    test_readout();
    test_reset_mid();
    test_start_collision();
`ifdef CONV_SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
